// File: rtl/kgp_ctrl_pkg.sv
// Shared encodings for the multi-cycle KGP-RISC control sequencer.
package kgp_ctrl_pkg;

  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_ALU_R = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_ALU_I = 6'h01;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_BR    = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BZ    = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_BNZ   = 6'h06;
  localparam logic [OPCODE_W-1:0] OP_BCY   = 6'h07;
  localparam logic [OPCODE_W-1:0] OP_BNCY  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_CALL  = 6'h09;
  localparam logic [OPCODE_W-1:0] OP_RET   = 6'h0A;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 6'h3F;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;  // PC+4
  localparam logic [1:0] PC_SRC_BR  = 2'd1;  // branch target
  localparam logic [1:0] PC_SRC_RS  = 2'd2;  // register rs

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [1:0] WB_SEL_LINK = 2'd2;

  // One bundle of every control output, so the decoder can clear them in one go.
  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       alu_en;
    logic       flag_write;
    logic       reg_write;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       alu_src_b;
    logic [1:0] wb_sel;
    logic       link_sel;
    logic       halted;
    logic       illegal_op;
    logic       mem_error;
  } ctrl_t;

  // HALT counts as legal: it is decoded, just not executed.
  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    return (op <= OP_RET) || (op == OP_HALT);
  endfunction

  function automatic logic br_taken(input logic [OPCODE_W-1:0] op,
                                    input logic zf, input logic cf);
    case (op)
      OP_BR:   return 1'b1;
      OP_BZ:   return zf;
      OP_BNZ:  return !zf;
      OP_BCY:  return cf;
      OP_BNCY: return !cf;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_wdog.sv
// Memory-port watchdog: counts stalled request cycles, flags a timeout.
module ctrl_mem_watchdog #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic timeout
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Restart on every state change, count each stalled request cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (waiting)   cnt <= cnt + 1'b1;
  end

  // Fires on the stalled cycle that brings the count to MEM_TIMEOUT,
  // so the FSM lands in FAULT on that same edge.
  assign timeout = waiting && (cnt == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle KGP-RISC control sequencer: FETCH/DECODE/EXEC/MEM/WB
// with a shared memory port and a stall watchdog.
module multi_cycle_ctrl
  import kgp_ctrl_pkg::*;
#(
  parameter int OPW         = 6,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] instr_opcode,
  input  logic           zero_flag,
  input  logic           carry_flag,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic [1:0]     pc_src,
  output logic           ir_write,
  output logic           alu_en,
  output logic           flag_write,
  output logic           reg_write,
  output logic           mem_req,
  output logic           mem_we,
  output logic           addr_sel,
  output logic           alu_src_b,
  output logic [1:0]     wb_sel,
  output logic           link_sel,
  output logic           halted,
  output logic           illegal_op,
  output logic           mem_error,
  output logic [2:0]     state
);

  state_t               state_q, state_d;
  ctrl_t                c;
  logic [OPCODE_W-1:0]  op;
  logic                 waiting, timeout, wd_clear;

  assign op = OPCODE_W'(instr_opcode);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_FAULT;
      end
      S_DECODE: begin
        if (op == OP_HALT)     state_d = S_HALT;
        else if (!is_legal(op)) state_d = S_FETCH;
        else                   state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_ALU_R, OP_ALU_I: state_d = S_WB;
          OP_LW, OP_SW:       state_d = S_MEM;
          default:            state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready)    state_d = (op == OP_LW) ? S_WB : S_FETCH;
        else if (timeout) state_d = S_FAULT;
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
  end

  // Output decode; everything is forced low while reset is held.
  always_comb begin
    c = '0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          c.mem_req  = 1'b1;
          c.addr_sel = 1'b0;
          if (mem_ready) begin
            c.ir_write = 1'b1;
            c.pc_write = 1'b1;
            c.pc_src   = PC_SRC_SEQ;
          end
        end
        S_DECODE: c.illegal_op = !is_legal(op);
        S_EXEC: begin
          case (op)
            OP_ALU_R, OP_ALU_I: begin
              c.alu_en     = 1'b1;
              c.flag_write = 1'b1;
              c.alu_src_b  = (op == OP_ALU_I);
            end
            OP_LW, OP_SW: begin
              c.alu_en    = 1'b1;
              c.alu_src_b = 1'b1;
            end
            OP_BR, OP_BZ, OP_BNZ, OP_BCY, OP_BNCY: begin
              if (br_taken(op, zero_flag, carry_flag)) begin
                c.pc_write = 1'b1;
                c.pc_src   = PC_SRC_BR;
              end
            end
            OP_CALL: begin
              c.pc_write  = 1'b1;
              c.pc_src    = PC_SRC_BR;
              c.reg_write = 1'b1;
              c.wb_sel    = WB_SEL_LINK;
              c.link_sel  = 1'b1;
            end
            OP_RET: begin
              c.pc_write = 1'b1;
              c.pc_src   = PC_SRC_RS;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          c.mem_req  = 1'b1;
          c.addr_sel = 1'b1;
          c.mem_we   = (op == OP_SW);
        end
        S_WB: begin
          c.reg_write = 1'b1;
          c.wb_sel    = (op == OP_LW) ? WB_SEL_MEM : WB_SEL_ALU;
        end
        S_HALT:  c.halted    = 1'b1;
        S_FAULT: c.mem_error = 1'b1;
        default: ;
      endcase
    end
  end

  // Any state change restarts the stall count, so FETCH and MEM each start from zero.
  assign waiting  = c.mem_req && !mem_ready;
  assign wd_clear = (state_d != state_q);

  ctrl_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .waiting (waiting),
    .timeout (timeout)
  );

  assign pc_write   = c.pc_write;
  assign pc_src     = c.pc_src;
  assign ir_write   = c.ir_write;
  assign alu_en     = c.alu_en;
  assign flag_write = c.flag_write;
  assign reg_write  = c.reg_write;
  assign mem_req    = c.mem_req;
  assign mem_we     = c.mem_we;
  assign addr_sel   = c.addr_sel;
  assign alu_src_b  = c.alu_src_b;
  assign wb_sel     = c.wb_sel;
  assign link_sel   = c.link_sel;
  assign halted     = c.halted;
  assign illegal_op = c.illegal_op;
  assign mem_error  = c.mem_error;
  assign state      = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed cycle table plus random run
// against a phase-queue model of the instruction sequence.
module tb_multi_cycle_ctrl;
  import kgp_ctrl_pkg::*;

  localparam int TO = 4;

  // Packed view of all outputs:
  // [19] pc_write [18:17] pc_src [16] ir_write [15] alu_en [14] flag_write
  // [13] reg_write [12] mem_req [11] mem_we [10] addr_sel [9] alu_src_b
  // [8:7] wb_sel [6] link_sel [5] halted [4] illegal_op [3] mem_error [2:0] state
  localparam logic [19:0] PCW  = 20'd1 << 19;
  localparam logic [19:0] PCS1 = 20'd1 << 17;
  localparam logic [19:0] PCS2 = 20'd1 << 18;
  localparam logic [19:0] IRW  = 20'd1 << 16;
  localparam logic [19:0] ALU  = 20'd1 << 15;
  localparam logic [19:0] FW   = 20'd1 << 14;
  localparam logic [19:0] RW   = 20'd1 << 13;
  localparam logic [19:0] MR   = 20'd1 << 12;
  localparam logic [19:0] MWE  = 20'd1 << 11;
  localparam logic [19:0] AS   = 20'd1 << 10;
  localparam logic [19:0] ASB  = 20'd1 << 9;
  localparam logic [19:0] WB2  = 20'd1 << 8;
  localparam logic [19:0] WB1  = 20'd1 << 7;
  localparam logic [19:0] LNK  = 20'd1 << 6;
  localparam logic [19:0] HLT  = 20'd1 << 5;
  localparam logic [19:0] ILL  = 20'd1 << 4;
  localparam logic [19:0] MER  = 20'd1 << 3;
  localparam logic [19:0] SF = 20'(S_FETCH),  SD = 20'(S_DECODE), SE = 20'(S_EXEC);
  localparam logic [19:0] SM = 20'(S_MEM),    SW = 20'(S_WB),     SH = 20'(S_HALT);
  localparam logic [19:0] SX = 20'(S_FAULT);

  logic clk, reset, zero_flag, carry_flag, mem_ready;
  logic [5:0] instr_opcode;
  logic pc_write, ir_write, alu_en, flag_write, reg_write, mem_req, mem_we;
  logic addr_sel, alu_src_b, link_sel, halted, illegal_op, mem_error;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] state;
  logic [19:0] act;

  multi_cycle_ctrl #(.OPW(6), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .instr_opcode(instr_opcode),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .alu_en(alu_en),
    .flag_write(flag_write), .reg_write(reg_write), .mem_req(mem_req),
    .mem_we(mem_we), .addr_sel(addr_sel), .alu_src_b(alu_src_b),
    .wb_sel(wb_sel), .link_sel(link_sel), .halted(halted),
    .illegal_op(illegal_op), .mem_error(mem_error), .state(state)
  );

  assign act = {pc_write, pc_src, ir_write, alu_en, flag_write, reg_write, mem_req,
                mem_we, addr_sel, alu_src_b, wb_sel, link_sel, halted, illegal_op,
                mem_error, state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input int idx, input logic [19:0] a, input logic [19:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s[%0d] got %05h want %05h", nm, idx, a, e);
  endtask

  typedef struct {
    string       name;
    logic        rst;
    logic [5:0]  op;
    logic        z, cy, rdy;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic r, input logic [5:0] op,
                     input logic z, input logic cy, input logic rdy, input logic [19:0] e);
    vec_t v;
    v.name = nm; v.rst = r; v.op = op; v.z = z; v.cy = cy; v.rdy = rdy; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [5:0] op, input logic z,
                       input logic cy, input logic rdy);
    reset = r; instr_opcode = op; zero_flag = z; carry_flag = cy; mem_ready = rdy;
  endtask

  // ---------------- reference model ----------------
  // Each decoded instruction enqueues the phases it still has to walk through;
  // an empty queue means the next thing is a fetch.
  localparam int P_EXEC = 1, P_MEM = 2, P_WB = 3;
  bit m_fetch, m_dec, m_halt, m_fault;
  int m_cnt;
  int q[$];

  task automatic m_stall();
    m_cnt++;
    if (m_cnt == TO) begin m_fault = 1; m_fetch = 0; q.delete(); end
  endtask

  task automatic m_pop();
    void'(q.pop_front());
    m_cnt = 0;
    if (q.size() == 0) m_fetch = 1;
  endtask

  task automatic model_step(input logic r, input logic [5:0] op, input logic z,
                            input logic cy, input logic rdy, output logic [19:0] e);
    bit taken;
    e = '0;
    if (r) begin
      m_fetch = 1; m_dec = 0; m_halt = 0; m_fault = 0; m_cnt = 0; q.delete();
    end else if (m_fault) e = MER | SX;
    else if (m_halt) e = HLT | SH;
    else if (m_fetch) begin
      e = MR | SF;
      if (rdy) begin e |= IRW | PCW; m_fetch = 0; m_dec = 1; m_cnt = 0; end
      else m_stall();
    end else if (m_dec) begin
      e = SD; m_dec = 0;
      if (op == 6'h3F) m_halt = 1;
      else if (op > 6'h0A) begin e |= ILL; m_fetch = 1; end
      else begin
        q.push_back(P_EXEC);
        if (op == 6'h02 || op == 6'h03) q.push_back(P_MEM);
        if (op <= 6'h02) q.push_back(P_WB);
      end
    end else begin
      case (q[0])
        P_EXEC: begin
          e = SE;
          if (op <= 6'h01) e |= ALU | FW | ((op == 6'h01) ? ASB : 20'd0);
          else if (op <= 6'h03) e |= ALU | ASB;
          else if (op <= 6'h08) begin
            taken = (op == 6'h04) || (op == 6'h05 && z) || (op == 6'h06 && !z) ||
                    (op == 6'h07 && cy) || (op == 6'h08 && !cy);
            if (taken) e |= PCW | PCS1;
          end else if (op == 6'h09) e |= PCW | PCS1 | RW | WB2 | LNK;
          else e |= PCW | PCS2;
          m_pop();
        end
        P_MEM: begin
          e = SM | MR | AS | ((op == 6'h03) ? MWE : 20'd0);
          if (rdy) m_pop(); else m_stall();
        end
        default: begin
          e = SW | RW | ((op == 6'h02) ? WB1 : 20'd0);
          m_pop();
        end
      endcase
    end
  endtask

  // ---------------- stimulus ----------------
  logic [19:0] e;
  logic [5:0]  rop;
  logic        rr;
  int          stuck;

  initial begin
    drive(1, 0, 0, 0, 0);
    // Directed per-cycle table.
    for (int i = 0; i < 3; i++) add("reset", 1, 6'h00, 0, 0, 0, 20'd0);
    add("rel_fetch", 0, 6'h00, 0, 0, 0, MR | SF);
    add("fetch_alu", 0, 6'h00, 0, 0, 1, MR | IRW | PCW | SF);
    add("dec_alu",   0, 6'h00, 0, 0, 0, SD);
    add("exec_alu",  0, 6'h00, 0, 0, 0, ALU | FW | SE);
    add("wb_alu",    0, 6'h00, 0, 0, 0, RW | SW);
    add("fetch_lw",  0, 6'h02, 0, 0, 1, MR | IRW | PCW | SF);
    add("dec_lw",    0, 6'h02, 0, 0, 0, SD);
    add("exec_lw",   0, 6'h02, 0, 0, 0, ALU | ASB | SE);
    add("mem_lw_w",  0, 6'h02, 0, 0, 0, MR | AS | SM);
    add("mem_lw_w",  0, 6'h02, 0, 0, 0, MR | AS | SM);
    add("mem_lw",    0, 6'h02, 0, 0, 1, MR | AS | SM);
    add("wb_lw",     0, 6'h02, 0, 0, 0, RW | WB1 | SW);
    add("fetch_bz",  0, 6'h05, 0, 0, 1, MR | IRW | PCW | SF);
    add("dec_bz",    0, 6'h05, 0, 0, 0, SD);
    add("bz_z0",     0, 6'h05, 0, 0, 0, SE);
    add("fetch_bz",  0, 6'h05, 1, 0, 1, MR | IRW | PCW | SF);
    add("dec_bz",    0, 6'h05, 1, 0, 0, SD);
    add("bz_z1",     0, 6'h05, 1, 0, 0, PCW | PCS1 | SE);
    add("fetch_bcy", 0, 6'h07, 0, 0, 1, MR | IRW | PCW | SF);
    add("dec_bcy",   0, 6'h07, 0, 0, 0, SD);
    add("bcy_c0",    0, 6'h07, 0, 0, 0, SE);
    add("fetch_bncy",0, 6'h08, 0, 0, 1, MR | IRW | PCW | SF);
    add("dec_bncy",  0, 6'h08, 0, 0, 0, SD);
    add("bncy_c0",   0, 6'h08, 0, 0, 0, PCW | PCS1 | SE);
    add("fetch_call",0, 6'h09, 0, 0, 1, MR | IRW | PCW | SF);
    add("dec_call",  0, 6'h09, 0, 0, 0, SD);
    add("exec_call", 0, 6'h09, 0, 0, 0, PCW | PCS1 | RW | WB2 | LNK | SE);
    add("fetch_ill", 0, 6'h1C, 0, 0, 1, MR | IRW | PCW | SF);
    add("dec_ill",   0, 6'h1C, 0, 0, 0, ILL | SD);
    add("fetch_sw",  0, 6'h03, 0, 0, 1, MR | IRW | PCW | SF);
    add("dec_sw",    0, 6'h03, 0, 0, 0, SD);
    add("exec_sw",   0, 6'h03, 0, 0, 0, ALU | ASB | SE);
    add("mem_sw",    0, 6'h03, 0, 0, 1, MR | MWE | AS | SM);
    add("fetch_alui",0, 6'h01, 0, 0, 1, MR | IRW | PCW | SF);
    add("dec_alui",  0, 6'h01, 0, 0, 0, SD);
    add("exec_alui", 0, 6'h01, 0, 0, 0, ALU | FW | ASB | SE);
    add("wb_alui",   0, 6'h01, 0, 0, 0, RW | SW);
    add("fetch_ret", 0, 6'h0A, 0, 0, 1, MR | IRW | PCW | SF);
    add("dec_ret",   0, 6'h0A, 0, 0, 0, SD);
    add("exec_ret",  0, 6'h0A, 0, 0, 0, PCW | PCS2 | SE);
    add("fetch_halt",0, 6'h3F, 0, 0, 1, MR | IRW | PCW | SF);
    add("dec_halt",  0, 6'h3F, 0, 0, 0, SD);
    add("halt",      0, 6'h3F, 0, 0, 0, HLT | SH);
    add("halt_hold", 0, 6'h3F, 0, 0, 1, HLT | SH);
    add("reset",     1, 6'h00, 0, 0, 0, 20'd0);
    for (int i = 0; i < TO; i++) add("wd_wait", 0, 6'h00, 0, 0, 0, MR | SF);
    add("fault",     0, 6'h00, 0, 0, 1, MER | SX);
    add("fault_hold",0, 6'h00, 0, 0, 1, MER | SX);
    add("reset",     1, 6'h00, 0, 0, 0, 20'd0);
    add("fetch_sw",  0, 6'h03, 0, 0, 1, MR | IRW | PCW | SF);
    add("dec_sw",    0, 6'h03, 0, 0, 0, SD);
    add("exec_sw",   0, 6'h03, 0, 0, 0, ALU | ASB | SE);
    add("mem_sw_w",  0, 6'h03, 0, 0, 0, MR | MWE | AS | SM);
    add("rst_in_mem",1, 6'h03, 0, 0, 0, 20'd0);
    add("refetch",   0, 6'h03, 0, 0, 0, MR | SF);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].cy, tbl[i].rdy);
      #1 chk(tbl[i].name, i, act, tbl[i].exp);
    end

    // Random run; first cycle is a reset so the model and DUT start aligned.
    rop = 6'h00; stuck = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rr = (i == 0) || ($urandom_range(0, 99) < 2) || (stuck > 3);
      if (m_fetch) begin
        if ($urandom_range(0, 99) < 4)       rop = 6'h3F;
        else if ($urandom_range(0, 99) < 8)  rop = 6'($urandom_range(11, 62));
        else                                 rop = 6'($urandom_range(0, 10));
      end
      drive(rr, rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) < 60);
      #1;
      model_step(reset, instr_opcode, zero_flag, carry_flag, mem_ready, e);
      chk("rand", i, act, e);
      stuck = (m_halt || m_fault) ? stuck + 1 : 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
